// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT    = CLK_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    generate
        if (CLK_PER_BIT < 4 || CLK_PER_BIT > 65535) begin : g_bad_rate
            $error("uart_rx: CLK_PER_BIT out of range 4..65535");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state, state_next;
    logic [1:0]  sync_ff;
    logic        rx_sync;
    logic [15:0] clk_cnt, clk_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  data_next;
    logic        valid_next, err_next;

    assign rx_sync = sync_ff[1];
    assign rx_busy = (state != S_IDLE);

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], rx_line};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            clk_cnt      <= 16'd0;
            bit_idx      <= 3'd0;
            shift_reg    <= 8'd0;
            rx_data      <= 8'd0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_next;
            clk_cnt      <= clk_cnt_next;
            bit_idx      <= bit_idx_next;
            shift_reg    <= shift_next;
            rx_data      <= data_next;
            rx_valid     <= valid_next;
            rx_frame_err <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt + 16'd1;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        data_next    = rx_data;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        case (state)
            S_IDLE: begin
                clk_cnt_next = 16'd0;
                if (!rx_sync) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = 16'd0;
                    bit_idx_next = 3'd0;
                    // A line already back high at mid start bit is treated as noise
                    state_next   = rx_sync ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = 16'd0;
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = 16'd0;
                    if (rx_sync) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end
            end

            S_WAIT_HIGH: begin
                // Stay here through a break so a held-low line cannot retrigger reception
                clk_cnt_next = 16'd0;
                if (rx_sync) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                clk_cnt_next = 16'd0;
                state_next   = S_IDLE;
            end
        endcase
    end

endmodule
